// File: rtl/comma_aligner_if.sv
// ============================================================================
// Module   : comma_aligner_if
// Brief    : Valid/ready stream bundle (tdata/tvalid/tready) with master and
//            slave views. Used for both the raw and the aligned side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface comma_aligner_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tready;

   modport master (
      output tdata,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

`default_nettype wire

// File: rtl/comma_aligner.sv
// ============================================================================
// Module   : comma_aligner (with helper priority_encoder)
// Brief    : Searches every bit offset of a raw deserialized stream for
//            SYNC_WORD, locks with hysteresis and forwards re-aligned words.
//            Optional macro COMMA_ALIGNER_SYNC_STRIP_EN drops aligned words
//            equal to SYNC_WORD instead of forwarding them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         req_i,
   output logic [$clog2(WIDTH)-1:0] idx_o,
   output logic                     valid_o
);
   localparam int c_ow = $clog2(WIDTH);

   // Scanning downward leaves the lowest set index as the final winner.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = c_ow'(i);
            valid_o = 1'b1;
         end
      end
   end
endmodule

module comma_aligner #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] SYNC_WORD    = 8'hBC,
   parameter int               LOCK_COUNT   = 4,
   parameter int               UNLOCK_COUNT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   comma_aligner_if.slave           s_axis,
   comma_aligner_if.master          m_axis,
   output logic                     locked,
   output logic [$clog2(WIDTH)-1:0] offset
);
   localparam int c_ow      = $clog2(WIDTH);
   localparam int c_cnt_max = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int c_cw      = $clog2(c_cnt_max + 1);

   localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
   localparam logic [c_cw-1:0] c_lock_max   = c_cw'(LOCK_COUNT);
   localparam logic [c_cw-1:0] c_lock_m1    = c_cw'(LOCK_COUNT - 1);
   localparam logic [c_cw-1:0] c_unlock_max = c_cw'(UNLOCK_COUNT);
   localparam logic [c_cw-1:0] c_unlock_m1  = c_cw'(UNLOCK_COUNT - 1);

   localparam logic [1:0] c_search = 2'd0;
   localparam logic [1:0] c_verify = 2'd1;
   localparam logic [1:0] c_locked = 2'd2;

   logic [1:0]         state_q,  state_d;
   logic [c_ow-1:0]    offset_q, offset_d;
   logic [c_cw-1:0]    cnt_q,    cnt_d;
   logic [c_cw-1:0]    miss_q,   miss_d;
   logic [WIDTH-1:0]   prev_q;
   logic               primed_q;
   logic               locked_q, locked_d;
   logic               tvalid_q, tvalid_d;
   logic [WIDTH-1:0]   tdata_q,  tdata_d;

   logic               w_accept;
   logic [2*WIDTH-1:0] w_win;
   logic [WIDTH-1:0]   w_match;
   logic [c_ow-1:0]    w_sel;
   logic               w_any;
   logic               w_hit;
   logic               w_miss;
   logic [WIDTH-1:0]   w_aligned;
   logic               w_fwd;

   assign s_axis.tready = !tvalid_q || m_axis.tready;
   assign w_accept      = s_axis.tvalid && s_axis.tready;

   // Newest word sits above the previous one, so low offsets favour older bits.
   assign w_win = {s_axis.tdata, prev_q};

   generate
      for (genvar k = 0; k < WIDTH; k++) begin : g_match
         assign w_match[k] = primed_q && (w_win[k +: WIDTH] == SYNC_WORD);
      end
   endgenerate

   priority_encoder #(
      .WIDTH (WIDTH)
   ) u_prio (
      .req_i   (w_match),
      .idx_o   (w_sel),
      .valid_o (w_any)
   );

   assign w_hit     = w_match[offset_q];
   assign w_miss    = w_any && !w_hit;
   assign w_aligned = w_win[offset_q +: WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_search;
      end else begin
         state_q <= state_d;
      end
   end

   // Beats with no match anywhere are neutral and leave counters untouched.
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      cnt_d    = cnt_q;
      miss_d   = miss_q;
      if (w_accept) begin
         case (state_q)
            c_search: begin
               if (w_any) begin
                  offset_d = w_sel;
                  cnt_d    = c_cnt_one;
                  miss_d   = '0;
                  state_d  = (LOCK_COUNT == 1) ? c_locked : c_verify;
               end
            end
            c_verify: begin
               if (w_hit) begin
                  if (cnt_q >= c_lock_m1) begin
                     cnt_d   = c_lock_max;
                     miss_d  = '0;
                     state_d = c_locked;
                  end else begin
                     cnt_d = cnt_q + c_cnt_one;
                  end
               end else if (w_miss) begin
                  offset_d = w_sel;
                  cnt_d    = c_cnt_one;
               end
            end
            c_locked: begin
               if (w_hit) begin
                  miss_d = '0;
               end else if (w_miss) begin
                  if (miss_q >= c_unlock_m1) begin
                     miss_d  = c_unlock_max;
                     state_d = c_search;
                  end else begin
                     miss_d = miss_q + c_cnt_one;
                  end
               end
            end
            default: begin
               state_d = c_search;
            end
         endcase
      end
   end

   always_comb begin
`ifdef COMMA_ALIGNER_SYNC_STRIP_EN
      w_fwd = w_accept && (state_q == c_locked) && (w_aligned != SYNC_WORD);
`else
      w_fwd = w_accept && (state_q == c_locked);
`endif
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      if (w_fwd) begin
         tvalid_d = 1'b1;
         tdata_d  = w_aligned;
      end else if (m_axis.tready) begin
         tvalid_d = 1'b0;
      end
      locked_d = (state_d == c_locked);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         offset_q <= '0;
         cnt_q    <= '0;
         miss_q   <= '0;
         prev_q   <= '0;
         primed_q <= 1'b0;
         locked_q <= 1'b0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
      end else begin
         offset_q <= offset_d;
         cnt_q    <= cnt_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         if (w_accept) begin
            prev_q   <= s_axis.tdata;
            primed_q <= 1'b1;
         end
      end
   end

   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tdata  = tdata_q;
   assign locked        = locked_q;
   assign offset        = offset_q;

endmodule

`default_nettype wire
